// File: rtl/bcd_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with a start/busy/done handshake and invalid-digit flag.
module bcd_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BIN_W-1:0]      o_binary,
  output logic                  o_err,
  output logic [1:0]            o_state
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [SR_W-1:0]    r_shift;
  logic [BIN_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err_flag;
  logic               r_busy;
  logic               r_done;
  logic [BIN_W-1:0]   r_binary;
  logic               r_err;

  state_t             w_state_nxt;
  logic [SR_W-1:0]    w_shift_nxt;
  logic [BIN_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_err_flag_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [BIN_W-1:0]   w_binary_nxt;
  logic               w_err_nxt;

  logic [3:0]         w_digit;
  logic [BIN_W-1:0]   w_acc_step;
  logic               w_err_step;
  logic               w_last;

  // Handshake: i_start is a request honoured only in IDLE (it is not queued);
  // o_busy is high from the accept edge until the result edge; o_done pulses
  // for one cycle with o_binary/o_err valid, and those two hold until the next result.
  assign w_digit    = r_shift[SR_W-1 -: 4];
  assign w_acc_step = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_digit);
  assign w_err_step = r_err_flag | (w_digit > 4'd9);
  assign w_last     = (r_cnt == CNT_W'(DIGITS - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_err_flag_nxt = r_err_flag;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_binary_nxt   = r_binary;
    w_err_nxt      = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_shift_nxt    = i_bcd;
          w_acc_nxt      = '0;
          w_cnt_nxt      = '0;
          w_err_flag_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_CONV;
        end
      end
      S_CONV: begin
        w_acc_nxt      = w_acc_step;
        w_err_flag_nxt = w_err_step;
        w_shift_nxt    = r_shift << 4;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        if (w_last) begin
          // Invalid words report zero rather than a truncated, meaningless value.
          w_binary_nxt = w_err_step ? '0 : w_acc_step;
          w_err_nxt    = w_err_step;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_binary   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_binary   <= w_binary_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_binary = r_binary;
  assign o_err    = r_err;
  assign o_state  = r_state;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Directed bench for bcd_bin_seq: a 4-digit instance for the main checks and
// exhaustive sweep, plus a 2-digit instance for latency and back-to-back rate.
module tb_bcd_bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic [13:0] binary;
  logic        err;
  logic [1:0]  state;

  logic        start2;
  logic [7:0]  bcd2;
  logic        busy2;
  logic        done2;
  logic [6:0]  binary2;
  logic        err2;
  logic [1:0]  state2;

  int n_total;
  int n_bad;
  logic [15:0] exp_q[$];

  bcd_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bcd(bcd),
    .o_busy(busy), .o_done(done), .o_binary(binary), .o_err(err), .o_state(state)
  );

  bcd_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bcd(bcd2),
    .o_busy(busy2), .o_done(done2), .o_binary(binary2), .o_err(err2), .o_state(state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  // Drive one start pulse and wait (bounded) for done; lat counts cycles after the accept edge.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cyc,
                          output int bin, output int e);
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    busy_cyc = 0;
    bin      = -1;
    e        = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        bin = int'(binary);
        e   = int'(err);
      end
    end
  endtask

  logic [15:0] dir_bcd [6] = '{16'h1234, 16'h0000, 16'h9999, 16'h12A4, 16'h0042, 16'hFFFF};
  int          dir_bin [6] = '{1234, 0, 9999, 0, 42, 0};
  int          dir_err [6] = '{0, 0, 0, 1, 0, 1};

  initial begin
    int lat, bc, bin, e, nd, first, gap, prev;
    n_total = 0;
    n_bad   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd    = '0;
    start2 = 1'b0;
    bcd2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_binary", int'(binary), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_state", int'(state), 0);
    rst = 1'b0;

    // directed vectors through the expected queue
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(16'(dir_bin[i]));
      run_conv(dir_bcd[i], lat, bc, bin, e);
      chk($sformatf("dir%0d_lat", i), lat, 4);
      chk($sformatf("dir%0d_busy", i), bc, 4);
      chk($sformatf("dir%0d_bin", i), bin, int'(exp_q.pop_front()));
      chk($sformatf("dir%0d_err", i), e, dir_err[i]);
      chk($sformatf("dir%0d_busy_at_done", i), int'(busy), 0);
    end

    // result held after done
    run_conv(16'h1234, lat, bc, bin, e);
    repeat (3) @(negedge clk);
    chk("hold_binary", int'(binary), 1234);
    chk("hold_done_low", int'(done), 0);
    chk("hold_state_idle", int'(state), 0);

    // start while busy is ignored; bcd change after accept has no effect
    @(negedge clk);
    bcd   = 16'h0500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bcd   = 16'h0777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd  = 0;
    bin = -1;
    for (int k = 0; k < 14; k++) begin
      if (done) begin
        nd++;
        bin = int'(binary);
      end
      @(negedge clk);
    end
    chk("busy_start_ndone", nd, 1);
    chk("busy_start_bin", bin, 500);

    // reset mid-conversion
    @(negedge clk);
    bcd   = 16'h9999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_binary", int'(binary), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_state", int'(state), 0);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("midrst_no_done", nd, 0);
    run_conv(16'h0010, lat, bc, bin, e);
    chk("after_rst_lat", lat, 4);
    chk("after_rst_bin", bin, 10);
    chk("after_rst_err", e, 0);

    // exhaustive sweep of valid 4-digit words
    for (int n = 0; n < 10000; n++) begin
      run_conv(to_bcd(n), lat, bc, bin, e);
      chk($sformatf("sweep%0d_bin", n), bin, n);
      chk($sformatf("sweep%0d_err", n), e, 0);
      if (lat != 4) chk($sformatf("sweep%0d_lat", n), lat, 4);
    end

    // 2-digit instance: single conversion latency
    @(negedge clk);
    bcd2   = 8'h99;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (done2) begin
        lat = k;
        bin = int'(binary2);
        e   = int'(err2);
      end
    end
    chk("d2_lat", lat, 2);
    chk("d2_bin", bin, 99);
    chk("d2_err", e, 0);

    // 2-digit instance: start held high gives done every 4 cycles
    @(negedge clk);
    bcd2   = 8'h37;
    start2 = 1'b1;
    nd    = 0;
    first = -1;
    prev  = -1;
    gap   = -1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (done2) begin
        nd++;
        chk($sformatf("d2_b2b_bin%0d", nd), int'(binary2), 37);
        if (first < 0) first = k;
        else if (gap < 0) gap = k - prev;
        else chk($sformatf("d2_b2b_gap%0d", nd), k - prev, 4);
        prev = k;
      end
    end
    start2 = 1'b0;
    chk("d2_b2b_first", first, 2);
    chk("d2_b2b_gap", gap, 4);
    chk("d2_b2b_count", nd, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
